rvfi_check_sequencer: RTL and testbench

- Sits directly upstream of the per-channel RVFI check modules (causal, register, PC checks) in the formal harness.
- Watches all retirement channels for the instruction whose rvfi_order equals a solver-chosen target.
- Produces the `check` strobe and channel index in the exact cycle that instruction retires.
- Then drains a fixed number of further cycles and raises `done`, bounding the proof depth. Also reports retirement-stream sanity errors.

---
 rtl/rvfi_seq_pkg.sv | 14 +
 rtl/rvfi_seq_match.sv | 26 ++
 rtl/rvfi_check_sequencer.sv | 111 +++++++++++
 tb/tb_rvfi_check_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_seq_pkg.sv
// rvfi_seq_pkg: shared types, widths and bit helpers for the RVFI check sequencer
package rvfi_seq_pkg;
    localparam int ORDER_W = 64;
    typedef enum logic [1:0] {WAIT = 2'd0, DRAIN = 2'd1, DONE = 2'd2} seq_state_t;
    function automatic logic [6:0] popcount(input logic [63:0] v);
        popcount = '0;
        for (int i = 0; i < 64; i++) popcount = popcount + 7'(v[i]);
    endfunction
    // Scans downward so the last assignment wins with the lowest set index; 0 when empty.
    function automatic logic [5:0] lowest_set(input logic [63:0] v);
        lowest_set = '0;
        for (int i = 63; i >= 0; i--) if (v[i]) lowest_set = 6'(i);
    endfunction
endpackage

// File: rtl/rvfi_seq_match.sv
// rvfi_seq_match: per-channel target compare, lowest matching channel and same-cycle duplicate order detect
module rvfi_seq_match
    import rvfi_seq_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int IDX_W = 1
) (
    input  logic [NRET-1:0]         valid,
    input  logic [ORDER_W*NRET-1:0] order,
    input  logic [ORDER_W-1:0]      target,
    output logic [NRET-1:0]         match,
    output logic [IDX_W-1:0]        match_idx,
    output logic                    dup
);
    for (genvar c = 0; c < NRET; c++) begin : g_cmp
        assign match[c] = valid[c] && order[ORDER_W*c +: ORDER_W] == target;
    end
    assign match_idx = IDX_W'(lowest_set(64'(match)));
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NRET; i++)
            for (int j = i + 1; j < NRET; j++)
                dup = dup | (valid[i] && valid[j] &&
                             order[ORDER_W*i +: ORDER_W] == order[ORDER_W*j +: ORDER_W]);
    end
endmodule

// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: strobes check when the target order retires, drains a fixed window, then raises done.
// Define RVFI_SEQ_ORDER_MONO_EN to add the order_err port for consecutive-order checking.
module rvfi_check_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET         = 1,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16,
    localparam int IDX_W       = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [ORDER_W*NRET-1:0] rvfi_order,
    input  logic [ORDER_W-1:0]      target_order,
    output logic                    check,
    output logic [IDX_W-1:0]        check_channel,
    output logic                    done,
    output logic [CNT_W-1:0]        retire_count,
    output logic                    dup_err,
    output logic [1:0]              state
`ifdef RVFI_SEQ_ORDER_MONO_EN
    ,
    output logic                    order_err
`endif
);
    localparam int PC_W = $clog2(NRET + 1);
    localparam int DC_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    seq_state_t       cur, nxt;
    logic [DC_W-1:0]  cnt;
    logic [NRET-1:0]  match;
    logic [IDX_W-1:0] idx;
    logic             dup, hit;
    logic [PC_W-1:0]  pc;
    logic [CNT_W:0]   sum;

    rvfi_seq_match #(.NRET(NRET), .IDX_W(IDX_W)) u_match (
        .valid     (rvfi_valid),
        .order     (rvfi_order),
        .target    (target_order),
        .match     (match),
        .match_idx (idx),
        .dup       (dup)
    );

    assign hit   = |match;
    assign state = cur;
    assign pc    = PC_W'(popcount(64'(rvfi_valid)));
    assign sum   = (CNT_W + 1)'(retire_count) + (CNT_W + 1)'(pc);

    always_ff @(posedge clock) begin
        if (reset) cur <= WAIT;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = WAIT;
        case (cur)
            WAIT:    nxt = hit ? ((DRAIN_CYCLES == 0) ? DONE : DRAIN) : WAIT;
            DRAIN:   nxt = (cnt == DC_W'(1)) ? DONE : DRAIN;
            DONE:    nxt = DONE;
            default: nxt = WAIT;
        endcase
    end

    // check is purely combinational so downstream checkers see it in the retire cycle itself.
    always_comb begin
        check         = !reset && cur == WAIT && hit;
        check_channel = check ? idx : '0;
        done          = cur == DONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            retire_count <= '0;
            dup_err      <= 1'b0;
        end else begin
            if (cur == WAIT && hit) cnt <= DC_W'(DRAIN_CYCLES);
            else if (cur == DRAIN)  cnt <= cnt - 1'b1;
            retire_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            dup_err      <= dup_err | dup | (cur != WAIT && hit);
        end
    end

`ifdef RVFI_SEQ_ORDER_MONO_EN
    logic [ORDER_W-1:0] next_expected, want;
    logic               mono_bad;
    // Valid channels take consecutive orders in index order; invalid channels are skipped.
    always_comb begin
        want     = next_expected;
        mono_bad = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (rvfi_valid[i]) begin
                mono_bad = mono_bad | (rvfi_order[ORDER_W*i +: ORDER_W] != want);
                want     = want + 64'd1;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            next_expected <= '0;
            order_err     <= 1'b0;
        end else begin
            next_expected <= want;
            order_err     <= order_err | mono_bad;
        end
    end
`endif
endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// tb_rvfi_check_sequencer: directed checks of target strobe, drain timing, sticky errors and counter saturation
module tb_rvfi_check_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    logic         valid1 = 1'b0;
    logic [63:0]  order1 = '0, target1 = '0;
    logic         check1, ch1, done1, dup1;
    logic [15:0]  cnt1;
    logic [1:0]   st1;

    logic [1:0]   valid2 = '0;
    logic [127:0] order2 = '0;
    logic [63:0]  target2 = '0;
    logic         check2, ch2, done2, dup2;
    logic [15:0]  cnt2;
    logic [1:0]   st2;

    logic         valid3 = 1'b0;
    logic [63:0]  order3 = '0, target3 = 64'hFFFF_FFFF_FFFF_FFFF;
    logic         check3, ch3, done3, dup3;
    logic [3:0]   cnt3;
    logic [1:0]   st3;
`ifdef RVFI_SEQ_ORDER_MONO_EN
    logic oe1, oe2, oe3;
`endif

    rvfi_check_sequencer #(.NRET(1), .DRAIN_CYCLES(4), .CNT_W(16)) u1 (
        .clock(clock), .reset(reset), .rvfi_valid(valid1), .rvfi_order(order1),
        .target_order(target1), .check(check1), .check_channel(ch1), .done(done1),
        .retire_count(cnt1), .dup_err(dup1), .state(st1)
`ifdef RVFI_SEQ_ORDER_MONO_EN
        , .order_err(oe1)
`endif
    );

    rvfi_check_sequencer #(.NRET(2), .DRAIN_CYCLES(4), .CNT_W(16)) u2 (
        .clock(clock), .reset(reset), .rvfi_valid(valid2), .rvfi_order(order2),
        .target_order(target2), .check(check2), .check_channel(ch2), .done(done2),
        .retire_count(cnt2), .dup_err(dup2), .state(st2)
`ifdef RVFI_SEQ_ORDER_MONO_EN
        , .order_err(oe2)
`endif
    );

    rvfi_check_sequencer #(.NRET(1), .DRAIN_CYCLES(4), .CNT_W(4)) u3 (
        .clock(clock), .reset(reset), .rvfi_valid(valid3), .rvfi_order(order3),
        .target_order(target3), .check(check3), .check_channel(ch3), .done(done3),
        .retire_count(cnt3), .dup_err(dup3), .state(st3)
`ifdef RVFI_SEQ_ORDER_MONO_EN
        , .order_err(oe3)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid1 = 1'b0;
        valid2 = '0;
        valid3 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        target1 = 64'd5;
        order1 = 64'd5;
        valid1 = 1'b1;
        #1;
        total++; if (check1 !== 1'b0) begin bad++; $display("FAIL reset_check got=%b want=0", check1); end
        tick();
        total++; if (st1 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done1); end
        total++; if (cnt1 !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt1); end
        total++; if (dup1 !== 1'b0) begin bad++; $display("FAIL reset_dup got=%b want=0", dup1); end
`ifdef RVFI_SEQ_ORDER_MONO_EN
        total++; if (oe1 !== 1'b0) begin bad++; $display("FAIL reset_order_err got=%b want=0", oe1); end
`endif
        valid1 = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_stream();
        do_reset();
        target1 = 64'd5;
        for (int o = 0; o < 10; o++) begin
            valid1 = 1'b1;
            order1 = 64'(o);
            #1;
            total++; if (check1 !== (o == 5)) begin bad++; $display("FAIL stream_check o=%0d got=%b want=%b", o, check1, o == 5); end
            if (o == 5) begin
                total++; if (ch1 !== 1'b0) begin bad++; $display("FAIL stream_channel got=%0d want=0", ch1); end
            end
            tick();
            total++; if (done1 !== (o >= 9)) begin bad++; $display("FAIL stream_done o=%0d got=%b want=%b", o, done1, o >= 9); end
        end
        valid1 = 1'b0;
        total++; if (cnt1 !== 16'd10) begin bad++; $display("FAIL stream_count got=%0d want=10", cnt1); end
        total++; if (st1 !== 2'd2) begin bad++; $display("FAIL stream_state got=%0d want=2", st1); end
        total++; if (dup1 !== 1'b0) begin bad++; $display("FAIL stream_dup got=%b want=0", dup1); end
`ifdef RVFI_SEQ_ORDER_MONO_EN
        total++; if (oe1 !== 1'b0) begin bad++; $display("FAIL stream_order_err got=%b want=0", oe1); end
`endif
    endtask

    task automatic test_same_cycle();
        do_reset();
        target2 = 64'd7;
        order2 = {64'd7, 64'd6};
        valid2 = 2'b11;
        #1;
        total++; if (check2 !== 1'b1) begin bad++; $display("FAIL pair_check got=%b want=1", check2); end
        total++; if (ch2 !== 1'b1) begin bad++; $display("FAIL pair_channel got=%0d want=1", ch2); end
        tick();
        valid2 = 2'b00;
        total++; if (dup2 !== 1'b0) begin bad++; $display("FAIL pair_dup got=%b want=0", dup2); end
        total++; if (st2 !== 2'd1) begin bad++; $display("FAIL pair_state got=%0d want=1", st2); end
        total++; if (cnt2 !== 16'd2) begin bad++; $display("FAIL pair_count got=%0d want=2", cnt2); end
    endtask

    task automatic test_dual_dup();
        do_reset();
        target2 = 64'd3;
        order2 = {64'd3, 64'd3};
        valid2 = 2'b11;
        #1;
        total++; if (check2 !== 1'b1) begin bad++; $display("FAIL dualdup_check got=%b want=1", check2); end
        total++; if (ch2 !== 1'b0) begin bad++; $display("FAIL dualdup_channel got=%0d want=0", ch2); end
        tick();
        valid2 = 2'b00;
        total++; if (dup2 !== 1'b1) begin bad++; $display("FAIL dualdup_dup got=%b want=1", dup2); end
        tick();
        total++; if (dup2 !== 1'b1) begin bad++; $display("FAIL dualdup_sticky got=%b want=1", dup2); end
    endtask

    task automatic test_dup_in_drain();
        do_reset();
        target1 = 64'd2;
        for (int o = 0; o < 3; o++) begin
            valid1 = 1'b1;
            order1 = 64'(o);
            tick();
        end
        order1 = 64'd2;
        #1;
        total++; if (check1 !== 1'b0) begin bad++; $display("FAIL drain_check got=%b want=0", check1); end
        tick();
        valid1 = 1'b0;
        total++; if (dup1 !== 1'b1) begin bad++; $display("FAIL drain_dup got=%b want=1", dup1); end
        tick();
        tick();
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL drain_done_early got=%b want=0", done1); end
        tick();
        total++; if (done1 !== 1'b1) begin bad++; $display("FAIL drain_done got=%b want=1", done1); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        target1 = 64'd0;
        order1 = 64'd0;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        total++; if (st1 !== 2'd1) begin bad++; $display("FAIL middrain_enter got=%0d want=1", st1); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (st1 !== 2'd0) begin bad++; $display("FAIL middrain_state got=%0d want=0", st1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL middrain_done got=%b want=0", done1); end
        total++; if (cnt1 !== 16'd0) begin bad++; $display("FAIL middrain_count got=%0d want=0", cnt1); end
        valid1 = 1'b1;
        #1;
        total++; if (check1 !== 1'b1) begin bad++; $display("FAIL middrain_recheck got=%b want=1", check1); end
        tick();
        valid1 = 1'b0;
        total++; if (st1 !== 2'd1) begin bad++; $display("FAIL middrain_redrain got=%0d want=1", st1); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            valid3 = 1'b1;
            order3 = 64'(i);
            tick();
            total++; if (cnt3 !== 4'((i + 1 > 15) ? 15 : i + 1)) begin bad++; $display("FAIL sat_count i=%0d got=%0d want=%0d", i, cnt3, (i + 1 > 15) ? 15 : i + 1); end
        end
        valid3 = 1'b0;
        tick();
        total++; if (cnt3 !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", cnt3); end
    endtask

`ifdef RVFI_SEQ_ORDER_MONO_EN
    task automatic test_order_mono();
        logic [63:0] seq [3];
        seq = '{64'd0, 64'd1, 64'd3};
        do_reset();
        target1 = 64'd100;
        for (int i = 0; i < 3; i++) begin
            valid1 = 1'b1;
            order1 = seq[i];
            tick();
            total++; if (oe1 !== (i == 2)) begin bad++; $display("FAIL mono_err i=%0d got=%b want=%b", i, oe1, i == 2); end
        end
        valid1 = 1'b0;
        tick();
        total++; if (oe1 !== 1'b1) begin bad++; $display("FAIL mono_sticky got=%b want=1", oe1); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_stream();
        test_same_cycle();
        test_dual_dup();
        test_dup_in_drain();
        test_reset_mid_drain();
        test_saturate();
`ifdef RVFI_SEQ_ORDER_MONO_EN
        test_order_mono();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
